// File: rtl/rf_wb_sched.sv
// Writeback scheduler for the 32x32 register file: round-robin sharing of the
// single rf write port between ALU and load-return paths, plus a busy scoreboard.
module rf_wb_sched #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned NUM_REGS    = 32,
  parameter bit          ZERO_REG_RO = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                alloc_valid_i,
  input  logic [ADDR_W-1:0]   alloc_dst_i,
  output logic                alloc_ready_o,
  input  logic                alu_valid_i,
  input  logic [ADDR_W-1:0]   alu_dst_i,
  input  logic [DATA_W-1:0]   alu_data_i,
  output logic                alu_ready_o,
  input  logic                ld_valid_i,
  input  logic [ADDR_W-1:0]   ld_dst_i,
  input  logic [DATA_W-1:0]   ld_data_i,
  output logic                ld_ready_o,
  input  logic [ADDR_W-1:0]   chk_sel1_i,
  input  logic [ADDR_W-1:0]   chk_sel2_i,
  output logic                chk_busy1_o,
  output logic                chk_busy2_o,
  output logic                rf_we_o,
  output logic [ADDR_W-1:0]   rf_dst_o,
  output logic [DATA_W-1:0]   rf_data_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic                err_o
);

  typedef enum logic {
    PRIO_ALU = 1'b0,
    PRIO_LD  = 1'b1
  } prio_e;

  prio_e               prio_q, prio_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_dst_q, rf_dst_d;
  logic [DATA_W-1:0]   rf_data_q, rf_data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                err_q, err_d;

  logic                alu_gnt_s;
  logic                ld_gnt_s;
  logic                wb_gnt_s;
  logic [ADDR_W-1:0]   wb_dst_s;
  logic [DATA_W-1:0]   wb_data_s;
  logic                alloc_acc_s;

  function automatic logic is_ro_zero(input logic [ADDR_W-1:0] dst);
    return ZERO_REG_RO && (dst == {ADDR_W{1'b0}});
  endfunction

  function automatic logic commit_hits(input logic we, input logic [ADDR_W-1:0] cdst,
                                       input logic [ADDR_W-1:0] sel);
    return we && (cdst == sel);
  endfunction

  // Arbitration: readiness depends only on the other requester's valid and the pointer.
  always_comb begin
    alu_ready_o   = 1'b0;
    ld_ready_o    = 1'b0;
    alloc_ready_o = 1'b0;
    if (rst_i) begin
      alu_ready_o   = 1'b0;
      ld_ready_o    = 1'b0;
      alloc_ready_o = 1'b0;
    end else begin
      alu_ready_o   = ~ld_valid_i  | (prio_q == PRIO_ALU);
      ld_ready_o    = ~alu_valid_i | (prio_q == PRIO_LD);
      alloc_ready_o = is_ro_zero(alloc_dst_i) | ~busy_q[alloc_dst_i]
                    | commit_hits(rf_we_q, rf_dst_q, alloc_dst_i);
    end
  end

  // Hazard checks see the commit in flight as already done (rf write-through).
  always_comb begin
    chk_busy1_o = busy_q[chk_sel1_i] & ~commit_hits(rf_we_q, rf_dst_q, chk_sel1_i);
    chk_busy2_o = busy_q[chk_sel2_i] & ~commit_hits(rf_we_q, rf_dst_q, chk_sel2_i);
  end

  // Winning writeback selection.
  always_comb begin
    alu_gnt_s   = alu_valid_i & alu_ready_o;
    ld_gnt_s    = ld_valid_i & ld_ready_o;
    alloc_acc_s = alloc_valid_i & alloc_ready_o;
    wb_gnt_s    = 1'b0;
    wb_dst_s    = {ADDR_W{1'b0}};
    wb_data_s   = {DATA_W{1'b0}};
    case ({alu_gnt_s, ld_gnt_s})
      2'b10: begin
        wb_gnt_s  = 1'b1;
        wb_dst_s  = alu_dst_i;
        wb_data_s = alu_data_i;
      end
      2'b01: begin
        wb_gnt_s  = 1'b1;
        wb_dst_s  = ld_dst_i;
        wb_data_s = ld_data_i;
      end
      default: begin
        wb_gnt_s  = 1'b0;
        wb_dst_s  = {ADDR_W{1'b0}};
        wb_data_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // Next state: pointer, write-port registers, scoreboard and sticky error.
  always_comb begin
    prio_d    = prio_q;
    rf_we_d   = 1'b0;
    rf_dst_d  = rf_dst_q;
    rf_data_d = rf_data_q;
    busy_d    = busy_q;
    err_d     = err_q;

    // The pointer only moves on contention; a lone requester leaves it alone.
    if (alu_valid_i && ld_valid_i && !rst_i) begin
      prio_d = (prio_q == PRIO_ALU) ? PRIO_LD : PRIO_ALU;
    end else begin
      prio_d = prio_q;
    end

    if (wb_gnt_s && !is_ro_zero(wb_dst_s)) begin
      rf_we_d   = 1'b1;
      rf_dst_d  = wb_dst_s;
      rf_data_d = wb_data_s;
    end else begin
      rf_we_d   = 1'b0;
    end

    if (rf_we_q) begin
      if (!busy_q[rf_dst_q]) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
      busy_d[rf_dst_q] = 1'b0;
    end else begin
      err_d = err_q;
    end

    // Applied after the commit clear so a same-edge allocation wins.
    if (alloc_acc_s && !is_ro_zero(alloc_dst_i)) begin
      busy_d[alloc_dst_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q    <= PRIO_ALU;
      rf_we_q   <= 1'b0;
      rf_dst_q  <= {ADDR_W{1'b0}};
      rf_data_q <= {DATA_W{1'b0}};
      busy_q    <= {NUM_REGS{1'b0}};
      err_q     <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      rf_we_q   <= rf_we_d;
      rf_dst_q  <= rf_dst_d;
      rf_data_q <= rf_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign rf_we_o   = rf_we_q;
  assign rf_dst_o  = rf_dst_q;
  assign rf_data_o = rf_data_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Randomized bench for rf_wb_sched: two instances (ZERO_REG_RO=0 and 1) share
// stimulus and are compared against a behavioural scoreboard/arbiter model.
module tb_rf_wb_sched;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic          alloc_valid_i;
  logic [AW-1:0] alloc_dst_i;
  logic          alu_valid_i;
  logic [AW-1:0] alu_dst_i;
  logic [DW-1:0] alu_data_i;
  logic          ld_valid_i;
  logic [AW-1:0] ld_dst_i;
  logic [DW-1:0] ld_data_i;
  logic [AW-1:0] chk_sel1_i;
  logic [AW-1:0] chk_sel2_i;

  logic          alloc_ready [2];
  logic          alu_ready [2];
  logic          ld_ready [2];
  logic          busy1 [2];
  logic          busy2 [2];
  logic          rf_we [2];
  logic [AW-1:0] rf_dst [2];
  logic [DW-1:0] rf_data [2];
  logic [NR-1:0] busy_v [2];
  logic          err [2];

  rf_wb_sched #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .ZERO_REG_RO(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i),
    .alloc_valid_i(alloc_valid_i), .alloc_dst_i(alloc_dst_i), .alloc_ready_o(alloc_ready[0]),
    .alu_valid_i(alu_valid_i), .alu_dst_i(alu_dst_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready[0]),
    .ld_valid_i(ld_valid_i), .ld_dst_i(ld_dst_i), .ld_data_i(ld_data_i), .ld_ready_o(ld_ready[0]),
    .chk_sel1_i(chk_sel1_i), .chk_sel2_i(chk_sel2_i),
    .chk_busy1_o(busy1[0]), .chk_busy2_o(busy2[0]),
    .rf_we_o(rf_we[0]), .rf_dst_o(rf_dst[0]), .rf_data_o(rf_data[0]),
    .busy_o(busy_v[0]), .err_o(err[0])
  );

  rf_wb_sched #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .ZERO_REG_RO(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i),
    .alloc_valid_i(alloc_valid_i), .alloc_dst_i(alloc_dst_i), .alloc_ready_o(alloc_ready[1]),
    .alu_valid_i(alu_valid_i), .alu_dst_i(alu_dst_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready[1]),
    .ld_valid_i(ld_valid_i), .ld_dst_i(ld_dst_i), .ld_data_i(ld_data_i), .ld_ready_o(ld_ready[1]),
    .chk_sel1_i(chk_sel1_i), .chk_sel2_i(chk_sel2_i),
    .chk_busy1_o(busy1[1]), .chk_busy2_o(busy2[1]),
    .rf_we_o(rf_we[1]), .rf_dst_o(rf_dst[1]), .rf_data_o(rf_data[1]),
    .busy_o(busy_v[1]), .err_o(err[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: set of pending registers per instance, last rf write, error flag.
  bit            mb [2][NR];
  bit            mwe [2];
  int            mdst [2];
  logic [DW-1:0] mdata [2];
  bit            merr [2];
  bit            mprio_ld;
  bit            g_alu;
  bit            g_ld;

  function automatic bit zro(input int k, input int d);
    return (k == 1) && (d == 0);
  endfunction

  function automatic bit m_chk(input int k, input int s);
    return mb[k][s] && !(mwe[k] && mdst[k] == s);
  endfunction

  function automatic logic [NR-1:0] m_vec(input int k);
    logic [NR-1:0] v;
    for (int r = 0; r < NR; r++) v[r] = mb[k][r];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NR; r++) mb[k][r] = 1'b0;
      mwe[k] = 1'b0; mdst[k] = 0; mdata[k] = '0; merr[k] = 1'b0;
    end
    mprio_ld = 1'b0;
  endtask

  // One clock: check at negedge against the model, advance the model, return at posedge+1.
  task automatic step();
    bit e_alu, e_ld;
    bit e_alloc [2];
    @(negedge clk);
    e_alu = !rst_i && (!ld_valid_i || !mprio_ld);
    e_ld  = !rst_i && (!alu_valid_i || mprio_ld);
    for (int k = 0; k < 2; k++) begin
      e_alloc[k] = !rst_i && (zro(k, int'(alloc_dst_i)) || !mb[k][alloc_dst_i]
                              || (mwe[k] && mdst[k] == int'(alloc_dst_i)));
      check_eq($sformatf("alu_ready%0d", k), 64'(alu_ready[k]), 64'(e_alu));
      check_eq($sformatf("ld_ready%0d", k), 64'(ld_ready[k]), 64'(e_ld));
      check_eq($sformatf("alloc_ready%0d", k), 64'(alloc_ready[k]), 64'(e_alloc[k]));
      check_eq($sformatf("chk_busy1_%0d", k), 64'(busy1[k]), 64'(m_chk(k, int'(chk_sel1_i))));
      check_eq($sformatf("chk_busy2_%0d", k), 64'(busy2[k]), 64'(m_chk(k, int'(chk_sel2_i))));
      check_eq($sformatf("rf_we%0d", k), 64'(rf_we[k]), 64'(mwe[k]));
      check_eq($sformatf("rf_dst%0d", k), 64'(rf_dst[k]), 64'(mdst[k]));
      check_eq($sformatf("rf_data%0d", k), 64'(rf_data[k]), 64'(mdata[k]));
      check_eq($sformatf("busy%0d", k), 64'(busy_v[k]), 64'(m_vec(k)));
      check_eq($sformatf("err%0d", k), 64'(err[k]), 64'(merr[k]));
    end
    g_alu = alu_valid_i && e_alu;
    g_ld  = ld_valid_i && e_ld;
    if (rst_i) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mwe[k]) begin
          if (!mb[k][mdst[k]]) merr[k] = 1'b1;
          mb[k][mdst[k]] = 1'b0;
        end
        if (alloc_valid_i && e_alloc[k] && !zro(k, int'(alloc_dst_i))) mb[k][alloc_dst_i] = 1'b1;
        mwe[k] = 1'b0;
        if (g_alu && !zro(k, int'(alu_dst_i))) begin
          mwe[k] = 1'b1; mdst[k] = int'(alu_dst_i); mdata[k] = alu_data_i;
        end else if (g_ld && !zro(k, int'(ld_dst_i))) begin
          mwe[k] = 1'b1; mdst[k] = int'(ld_dst_i); mdata[k] = ld_data_i;
        end
      end
      if (alu_valid_i && ld_valid_i) mprio_ld = !mprio_ld;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid_i = 1'b0; alloc_dst_i = '0;
    alu_valid_i = 1'b0; alu_dst_i = '0; alu_data_i = '0;
    ld_valid_i = 1'b0; ld_dst_i = '0; ld_data_i = '0;
    chk_sel1_i = '0; chk_sel2_i = '0;
  endtask

  task automatic do_alloc(input logic [AW-1:0] d);
    alloc_valid_i = 1'b1; alloc_dst_i = d;
    step();
    alloc_valid_i = 1'b0;
  endtask

  // Writebacks mostly target registers that are actually pending.
  function automatic logic [AW-1:0] pick_dst();
    int r;
    if ($urandom_range(0, 3) != 0) begin
      for (int t = 0; t < 8; t++) begin
        r = int'($urandom_range(0, NR - 1));
        if (mb[0][r]) return AW'(r);
      end
    end
    return AW'($urandom_range(0, 7));
  endfunction

  bit            pa, pl;
  logic [AW-1:0] pa_dst, pl_dst;
  logic [DW-1:0] pa_data, pl_data;

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    step();
    rst_i = 1'b0;

    // Idle sweep over every select.
    for (int s = 0; s < NR; s++) begin
      chk_sel1_i = AW'(s); chk_sel2_i = AW'(NR - 1 - s);
      step();
    end

    // Allocate then commit reg 7.
    do_alloc(5'd7);
    alu_valid_i = 1'b1; alu_dst_i = 5'd7; alu_data_i = 32'hDEADBEEF; chk_sel1_i = 5'd7;
    #1;
    check_eq("wb7_ready", 64'(alu_ready[0]), 64'd1);
    step();
    alu_valid_i = 1'b0;
    #1;
    check_eq("wb7_we", 64'(rf_we[0]), 64'd1);
    check_eq("wb7_dst", 64'(rf_dst[0]), 64'd7);
    check_eq("wb7_data", 64'(rf_data[0]), 64'hDEADBEEF);
    check_eq("wb7_chk", 64'(busy1[0]), 64'd0);
    step();
    check_eq("wb7_cleared", 64'(busy_v[0][7]), 64'd0);

    // Contention from reset priority: ALU first, load second.
    do_alloc(5'd3);
    do_alloc(5'd4);
    alu_valid_i = 1'b1; alu_dst_i = 5'd3; alu_data_i = 32'h0000_0333;
    ld_valid_i = 1'b1; ld_dst_i = 5'd4; ld_data_i = 32'h0000_0444;
    #1;
    check_eq("arb_alu_rdy", 64'(alu_ready[0]), 64'd1);
    check_eq("arb_ld_wait", 64'(ld_ready[0]), 64'd0);
    step();
    check_eq("arb_first_dst", 64'(rf_dst[0]), 64'd3);
    alu_valid_i = 1'b0;
    #1;
    check_eq("arb_ld_rdy", 64'(ld_ready[0]), 64'd1);
    step();
    ld_valid_i = 1'b0;
    check_eq("arb_second_we", 64'(rf_we[0]), 64'd1);
    check_eq("arb_second_dst", 64'(rf_dst[0]), 64'd4);
    step();
    step();
    check_eq("arb_busy43", 64'(busy_v[0][4:3]), 64'd0);

    // WAW block on reg 9, then set-wins on the commit cycle.
    do_alloc(5'd9);
    alloc_valid_i = 1'b1; alloc_dst_i = 5'd9;
    alu_valid_i = 1'b1; alu_dst_i = 5'd9; alu_data_i = 32'h9999_0009;
    #1;
    check_eq("waw_block", 64'(alloc_ready[0]), 64'd0);
    step();
    alu_valid_i = 1'b0;
    #1;
    check_eq("waw_commit_rdy", 64'(alloc_ready[0]), 64'd1);
    step();
    alloc_valid_i = 1'b0;
    check_eq("waw_set_wins", 64'(busy_v[0][9]), 64'd1);
    check_eq("waw_no_err", 64'(err[0]), 64'd0);

    // Commit to a non-busy register: write happens and error is sticky.
    alu_valid_i = 1'b1; alu_dst_i = 5'd12; alu_data_i = 32'h1212_1212;
    step();
    alu_valid_i = 1'b0;
    step();
    check_eq("err_set", 64'(err[0]), 64'd1);
    check_eq("err_data", 64'(rf_data[0]), 64'h1212_1212);
    repeat (3) step();
    check_eq("err_sticky", 64'(err[0]), 64'd1);

    // Reset drops the accepted write and all busy bits.
    do_alloc(5'd1);
    do_alloc(5'd2);
    do_alloc(5'd5);
    alu_valid_i = 1'b1; alu_dst_i = 5'd1; alu_data_i = 32'h0101_0101;
    step();
    alu_valid_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check_eq("rst_we", 64'(rf_we[0]), 64'd0);
    check_eq("rst_busy", 64'(busy_v[0]), 64'd0);
    check_eq("rst_err", 64'(err[0]), 64'd0);

    // Register 0: read-only on instance 1, ordinary on instance 0.
    alloc_valid_i = 1'b1; alloc_dst_i = 5'd0;
    #1;
    check_eq("r0_alloc_rdy", 64'(alloc_ready[1]), 64'd1);
    step();
    alloc_valid_i = 1'b0;
    check_eq("r0_busy_ro", 64'(busy_v[1][0]), 64'd0);
    check_eq("r0_busy_rw", 64'(busy_v[0][0]), 64'd1);
    alu_valid_i = 1'b1; alu_dst_i = 5'd0; alu_data_i = 32'hA5A5_A5A5;
    #1;
    check_eq("r0_wb_rdy", 64'(alu_ready[1]), 64'd1);
    step();
    alu_valid_i = 1'b0;
    check_eq("r0_we_ro", 64'(rf_we[1]), 64'd0);
    check_eq("r0_we_rw", 64'(rf_we[0]), 64'd1);
    step();
    check_eq("r0_err_ro", 64'(err[1]), 64'd0);

    // Randomized traffic with requesters holding until granted.
    pa = 1'b0; pl = 1'b0;
    pa_dst = '0; pl_dst = '0; pa_data = '0; pl_data = '0;
    for (int i = 0; i < 3000; i++) begin
      rst_i = ($urandom_range(0, 99) < 2);
      if (!pa && $urandom_range(0, 99) < 50) begin
        pa = 1'b1; pa_dst = pick_dst(); pa_data = $urandom;
      end
      if (!pl && $urandom_range(0, 99) < 50) begin
        pl = 1'b1; pl_dst = pick_dst(); pl_data = $urandom;
      end
      alu_valid_i = pa; alu_dst_i = pa_dst; alu_data_i = pa_data;
      ld_valid_i = pl; ld_dst_i = pl_dst; ld_data_i = pl_data;
      alloc_valid_i = 1'($urandom_range(0, 1));
      alloc_dst_i = AW'($urandom_range(0, 7));
      chk_sel1_i = AW'($urandom_range(0, 7));
      chk_sel2_i = ($urandom_range(0, 1) == 1) ? AW'(mdst[0]) : AW'($urandom_range(0, NR - 1));
      step();
      if (rst_i) begin
        pa = 1'b0; pl = 1'b0;
      end else begin
        if (g_alu) pa = 1'b0;
        if (g_ld) pl = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
